ysyx_22041211_mem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (load/store). It sits between both fetch and load/store units and the memory model, serialising one transaction at a time over a valid/ready request channel and a single-pulse response channel. It routes each response back to the unit that issued the request.

---
 rtl/ysyx_22041211_mem_arbiter_pkg.sv | 19 +
 rtl/ysyx_22041211_arb_sel.sv | 36 +++
 rtl/ysyx_22041211_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owner ids and store byte masks.
// Round-robin arbitration is selected by defining ARB_ROUND_ROBIN_EN (tested only in ysyx_22041211_arb_sel).
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam logic ARB_OWN_IFU = 1'b0;
    localparam logic ARB_OWN_LSU = 1'b1;

    localparam logic [7:0] MEM_MASK_8  = 8'b0000_0001;
    localparam logic [7:0] MEM_MASK_16 = 8'b0000_0011;
    localparam logic [7:0] MEM_MASK_32 = 8'b0000_1111;

endpackage

// File: rtl/ysyx_22041211_arb_sel.sv
// Combinational grant selection between IFU and LSU.
// ARB_ROUND_ROBIN_EN defined: alternate on contention using last_grant; otherwise LSU has fixed priority.
module ysyx_22041211_arb_sel
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_ifu,
    output logic grant_lsu
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_valid && lsu_valid) begin
            grant_lsu = (last_grant == ARB_OWN_IFU);
            grant_ifu = (last_grant == ARB_OWN_LSU);
        end else begin
            grant_ifu = ifu_valid;
            grant_lsu = lsu_valid;
        end
    end
`else
    // last_grant only matters for round-robin; keep the port for a uniform interface.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_lsu = lsu_valid;
        grant_ifu = ifu_valid && !lsu_valid;
    end
`endif

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Serialises IFU and LSU requests onto one memory port and routes each response to its issuer.
// Arbitration policy follows ARB_ROUND_ROBIN_EN (see ysyx_22041211_arb_sel).
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    input  logic [ADDR_LEN-1:0] ifu_req_addr,
    output logic                ifu_req_ready,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_resp_data,
    input  logic                lsu_req_valid,
    input  logic                lsu_req_wen,
    input  logic [ADDR_LEN-1:0] lsu_req_addr,
    input  logic [DATA_LEN-1:0] lsu_req_wdata,
    input  logic [7:0]          lsu_req_wmask,
    output logic                lsu_req_ready,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_LEN-1:0] mem_req_addr,
    output logic [DATA_LEN-1:0] mem_req_wdata,
    output logic [7:0]          mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_resp_data,
    output logic                busy
);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wen_q, wen_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;
    logic [DATA_LEN-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_LEN-1:0] lsu_rdata_q, lsu_rdata_d;
    logic                grant_ifu, grant_lsu;

    ysyx_22041211_arb_sel u_arb_sel (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    // Grants already include the matching req_valid, so ready never depends on mem_* inputs.
    assign ifu_req_ready  = (state_q == ARB_IDLE) && grant_ifu;
    assign lsu_req_ready  = (state_q == ARB_IDLE) && grant_lsu;
    assign ifu_resp_valid = (state_q == ARB_RESP) && (owner_q == ARB_OWN_IFU);
    assign lsu_resp_valid = (state_q == ARB_RESP) && (owner_q == ARB_OWN_LSU);
    assign ifu_resp_data  = ifu_rdata_q;
    assign lsu_resp_data  = lsu_rdata_q;
    assign mem_req_valid  = (state_q == ARB_ISSUE);
    assign mem_req_wen    = wen_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign busy           = (state_q != ARB_IDLE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (lsu_req_ready) begin
                    wen_d        = lsu_req_wen;
                    addr_d       = lsu_req_addr;
                    wdata_d      = lsu_req_wdata;
                    wmask_d      = lsu_req_wmask;
                    owner_d      = ARB_OWN_LSU;
                    last_grant_d = ARB_OWN_LSU;
                    state_d      = ARB_ISSUE;
                end else if (ifu_req_ready) begin
                    wen_d        = 1'b0;
                    addr_d       = ifu_req_addr;
                    wdata_d      = '0;
                    wmask_d      = 8'h00;
                    owner_d      = ARB_OWN_IFU;
                    last_grant_d = ARB_OWN_IFU;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    if (owner_q == ARB_OWN_LSU) lsu_rdata_d = mem_resp_data;
                    else                        ifu_rdata_d = mem_resp_data;
                    state_d = ARB_RESP;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWN_IFU;
            last_grant_q <= ARB_OWN_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= 8'h00;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

endmodule
